// File: rtl/instr_encoder_if.sv
// Request channel of the instruction encoder: symbolic instruction fields
// plus a valid/ready handshake.
interface instr_encoder_if;
    logic        InValid;
    logic        InReady;
    logic [2:0]  Op;
    logic [4:0]  Rd;
    logic [4:0]  Rn;
    logic [4:0]  Rm;
    logic [18:0] Imm;

    modport master (
        output InValid, Op, Rd, Rn, Rm, Imm,
        input  InReady
    );

    modport slave (
        input  InValid, Op, Rd, Rn, Rm, Imm,
        output InReady
    );
endinterface

// File: rtl/instr_encoder.sv
// Assembles LEGv8 machine words from symbolic requests and writes them
// sequentially into instruction memory, one word per two cycles.
module instr_encoder #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_encoder_if.slave        bus,
    input  logic                  Clear,
    output logic                  MemWrEn,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [31:0]           MemData,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Full,
    output logic                  Error
);
    localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [31:0]           r_data;
    logic                  r_err;
    logic                  w_accept;
    logic                  w_legal;
    logic                  w_imm_ok;
    logic [31:0]           w_word;

    assign Full        = (r_count == CAP);
    assign bus.InReady = (r_state == IDLE) && !Full && !Clear;
    assign w_accept    = bus.InValid && bus.InReady;
    assign w_imm_ok    = (bus.Imm[18:8] == {11{bus.Imm[8]}});

    assign MemWrEn = (r_state == WRITE);
    assign MemAddr = r_ptr;
    assign MemData = r_data;
    assign Count   = r_count;
    assign Error   = r_err;

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        unique case (bus.Op)
            3'd0: w_word = {11'b10001011000, bus.Rm, 6'b0, bus.Rn, bus.Rd};
            3'd1: w_word = {11'b11001011000, bus.Rm, 6'b0, bus.Rn, bus.Rd};
            3'd2: w_word = {11'b10001010000, bus.Rm, 6'b0, bus.Rn, bus.Rd};
            3'd3: w_word = {11'b10101010000, bus.Rm, 6'b0, bus.Rn, bus.Rd};
            3'd4: begin
                w_word  = {11'b11111000010, bus.Imm[8:0], 2'b00, bus.Rn, bus.Rd};
                w_legal = w_imm_ok;
            end
            3'd5: begin
                w_word  = {11'b11111000000, bus.Imm[8:0], 2'b00, bus.Rn, bus.Rd};
                w_legal = w_imm_ok;
            end
            3'd6: w_word = {8'b10110100, bus.Imm, bus.Rd};
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept && w_legal) w_next = WRITE;
            WRITE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (r_state == WRITE) begin
            // The write already went out; Clear only redirects the pointer.
            if (Clear) begin
                r_ptr   <= '0;
                r_count <= '0;
                r_err   <= 1'b0;
            end else begin
                r_count <= r_count + 1'b1;
                if (~&r_ptr) r_ptr <= r_ptr + 1'b1;
            end
        end else if (Clear) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            if (w_legal) r_data <= w_word;
            else         r_err  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed checks of instr_encoder against a
// word-level reference model of the encoder and its memory pointer.
module tb_instr_encoder;
    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          Clear = 1'b0;
    logic          MemWrEn;
    logic [AW-1:0] MemAddr;
    logic [31:0]   MemData;
    logic [AW:0]   Count;
    logic          Full;
    logic          Error;

    instr_encoder_if bus ();

    instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .Clear   (Clear),
        .MemWrEn (MemWrEn),
        .MemAddr (MemAddr),
        .MemData (MemData),
        .Count   (Count),
        .Full    (Full),
        .Error   (Error)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: words written so far, pending write, last word, error.
    bit        m_busy;
    int        m_cnt;
    bit [31:0] m_data;
    bit        m_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit m_legal(input bit [2:0] op, input bit [18:0] imm);
        int s;
        if (op == 3'd7) return 1'b0;
        if (op == 3'd4 || op == 3'd5) begin
            s = int'($signed(imm));
            return (s >= -256) && (s <= 255);
        end
        return 1'b1;
    endfunction

    function automatic bit [31:0] m_word(input bit [2:0] op,
                                         input bit [4:0] rd, input bit [4:0] rn,
                                         input bit [4:0] rm, input bit [18:0] imm);
        bit [31:0] opc [6];
        opc[0] = 32'h458; opc[1] = 32'h658; opc[2] = 32'h450;
        opc[3] = 32'h550; opc[4] = 32'h7C2; opc[5] = 32'h7C0;
        if (op <= 3'd3)
            return opc[op] * (1 << 21) + rm * (1 << 16) + rn * 32 + rd;
        if (op <= 3'd5)
            return opc[op] * (1 << 21) + (imm % 512) * 4096 + rn * 32 + rd;
        return 32'd180 * (1 << 24) + imm * 32 + rd;
    endfunction

    task automatic m_reset();
        m_busy = 0; m_cnt = 0; m_data = '0; m_err = 0;
    endtask

    task automatic step(input bit v, input bit [2:0] op, input bit [4:0] rd,
                        input bit [4:0] rn, input bit [4:0] rm,
                        input bit [18:0] imm, input bit clr);
        bit rdy;
        @(negedge clk);
        bus.InValid = v; bus.Op = op; bus.Rd = rd;
        bus.Rn = rn; bus.Rm = rm; bus.Imm = imm; Clear = clr;
        #1;
        rdy = !m_busy && (m_cnt != CAP) && !clr;
        chk("ready", bus.InReady, rdy);
        chk("full", Full, m_cnt == CAP);
        chk("wren", MemWrEn, m_busy);
        chk("count", Count, m_cnt);
        chk("error", Error, m_err);
        if (m_busy) begin
            chk("addr", MemAddr, m_cnt);
            chk("data", MemData, m_data);
        end
        @(posedge clk);
        if (m_busy) begin
            m_busy = 0;
            if (clr) begin m_cnt = 0; m_err = 0; end
            else m_cnt++;
        end else if (clr) begin
            m_cnt = 0; m_err = 0;
        end else if (v && rdy) begin
            if (m_legal(op, imm)) begin
                m_data = m_word(op, rd, rn, rm, imm);
                m_busy = 1;
            end else m_err = 1;
        end
    endtask

    task automatic idle(input bit clr);
        step(0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0, clr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.InValid = 0; bus.Op = 0; bus.Rd = 0;
        bus.Rn = 0; bus.Rm = 0; bus.Imm = 0; Clear = 0;
        rst = 1;
        #2;
        chk("rst_wren", MemWrEn, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_data", MemData, 0);
        chk("rst_count", Count, 0);
        chk("rst_error", Error, 0);
        m_reset();
        rst = 0;
    endtask

    initial begin
        m_reset();
        do_reset();

        step(1, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0, 0);
        #1;
        chk("tp1_wren", MemWrEn, 1);
        chk("tp1_addr", MemAddr, 0);
        chk("tp1_data", MemData, 32'h8B030041);
        idle(0);
        #1 chk("tp1_count", Count, 1);

        do_reset();
        step(1, 3'd4, 5'd9, 5'd10, 5'd0, 19'd8, 0);
        #1;
        chk("tp2_ldur", MemData, 32'hF8408149);
        chk("tp2_ldur_addr", MemAddr, 0);
        chk("tp2_ldur_rdy", bus.InReady, 0);
        idle(0);
        step(1, 3'd5, 5'd9, 5'd10, 5'd0, 19'h7FFF8, 0);
        #1;
        chk("tp2_stur", MemData, 32'hF81F8149);
        chk("tp2_stur_addr", MemAddr, 1);
        chk("tp2_stur_rdy", bus.InReady, 0);
        idle(0);

        step(1, 3'd6, 5'd5, 5'd0, 5'd0, 19'h7FFFE, 0);
        #1 chk("tp3_cbz", MemData, 32'hB4FFFFC5);
        idle(0);
        step(1, 3'd4, 5'd1, 5'd1, 5'd0, 19'd300, 0);
        #1;
        chk("tp3_err", Error, 1);
        chk("tp3_nowr", MemWrEn, 0);
        chk("tp3_count", Count, 3);
        idle(1);
        #1;
        chk("tp3_clr_err", Error, 0);
        chk("tp3_clr_cnt", Count, 0);

        for (int i = 0; i < 10; i++) step(1, 3'd0, 5'd4, 5'd5, 5'd6, 19'd0, 0);
        #1;
        chk("tp4_full", Full, 1);
        chk("tp4_rdy", bus.InReady, 0);
        chk("tp4_err", Error, 0);
        chk("tp4_count", Count, CAP);

        idle(1);
        for (int i = 0; i < 2; i++) begin
            step(1, 3'd1, 5'd7, 5'd8, 5'd9, 19'd0, 0);
            idle(0);
        end
        step(1, 3'd2, 5'd7, 5'd8, 5'd9, 19'd0, 0);
        #1 chk("tp5_addr", MemAddr, 2);
        idle(1);
        #1 chk("tp5_count", Count, 0);
        step(1, 3'd3, 5'd1, 5'd1, 5'd1, 19'd0, 0);
        #1 chk("tp5_addr0", MemAddr, 0);
        idle(0);

        step(1, 3'd0, 5'd2, 5'd2, 5'd2, 19'd0, 0);
        #1 rst = 1;
        #1;
        chk("tp6_wren", MemWrEn, 0);
        chk("tp6_count", Count, 0);
        m_reset();
        rst = 0;
        step(1, 3'd0, 5'd1, 5'd2, 5'd3, 19'd0, 0);
        #1;
        chk("tp6_addr", MemAddr, 0);
        chk("tp6_wren2", MemWrEn, 1);

        for (int i = 0; i < 600; i++) begin
            bit [18:0] imm;
            int s;
            if ($urandom_range(0, 1) == 0) begin
                s = int'($urandom_range(0, 600)) - 300;
                imm = 19'(s);
            end else imm = 19'($urandom);
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 5'($urandom), 5'($urandom), 5'($urandom), imm,
                 $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
